fractal_engine: RTL and testbench

//  Parametrised successor pixel generator: Julia or Mandelbrot escape-time per pixel, raster order.

---
 rtl/fractal_pkg.sv | 28 ++
 rtl/fractal_iter_step.sv | 38 +++
 rtl/fractal_engine.sv | 176 +++++++++++++++++
 tb/tb_fractal_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared types, default widths and helpers for the escape-time pixel engine.
package fractal_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int FRAC_BITS_DEF = 28;
  localparam int ITER_W_DEF    = 8;
  localparam int DIM_W_DEF     = 16;

  typedef logic signed [DATA_W_DEF-1:0] fx_t;

  typedef enum logic {
    MODE_JULIA      = 1'b0,
    MODE_MANDELBROT = 1'b1
  } fractal_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_ITER,
    ST_OUT
  } state_e;

  // |z|^2 threshold of 4.0 expressed in the doubled-fraction product domain
  function automatic logic [127:0] escape_limit(input int frac_bits);
    escape_limit = 128'd4 << (2 * frac_bits);
  endfunction

endpackage

// File: rtl/fractal_iter_step.sv
// One combinational z -> z^2 + c step with escape test, in signed fixed point.
module fractal_iter_step
  import fractal_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [DATA_W-1:0] zr,
  input  logic signed [DATA_W-1:0] zi,
  input  logic signed [DATA_W-1:0] cr,
  input  logic signed [DATA_W-1:0] ci,
  output logic signed [DATA_W-1:0] zr_next,
  output logic signed [DATA_W-1:0] zi_next,
  output logic                     escape
);

  localparam int PW = 2 * DATA_W;
  localparam int LW = PW + 1;
  localparam logic signed [LW-1:0] LIMIT = LW'(escape_limit(FRAC_BITS));

  logic signed [PW-1:0] sr;
  logic signed [PW-1:0] si;
  logic signed [PW-1:0] p;
  logic signed [LW-1:0] mag;

  assign sr = PW'(zr) * PW'(zr);
  assign si = PW'(zi) * PW'(zi);
  assign p  = PW'(zr) * PW'(zi);

  // one extra bit keeps sr+si from overflowing when both squares are near full scale
  assign mag    = LW'(sr) + LW'(si);
  assign escape = mag > LIMIT;

  // shifting p by one less than the fraction width folds in the factor of two
  assign zr_next = DATA_W'((sr - si) >>> FRAC_BITS) + cr;
  assign zi_next = DATA_W'(p >>> (FRAC_BITS - 1)) + ci;

endmodule

// File: rtl/fractal_engine.sv
// Raster-order Julia/Mandelbrot escape-time generator with a valid/ready pixel stream.
module fractal_engine
  import fractal_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ITER_W    = ITER_W_DEF,
  parameter int DIM_W     = DIM_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mode,
  input  logic [ITER_W-1:0]        max_iter,
  input  logic [DIM_W-1:0]         width,
  input  logic [DIM_W-1:0]         height,
  input  logic signed [DATA_W-1:0] cr,
  input  logic signed [DATA_W-1:0] ci,
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] y0,
  input  logic signed [DATA_W-1:0] dx,
  input  logic signed [DATA_W-1:0] dy,
  output logic [ITER_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_user,
  output logic                     m_last,
  output logic                     busy
);

  state_e state, state_next;

  fractal_mode_e             mode_q;
  logic [ITER_W-1:0]         max_iter_q;
  logic [DIM_W-1:0]          width_q;
  logic [DIM_W-1:0]          height_q;
  logic signed [DATA_W-1:0]  cr_q, ci_q, x0_q, dx_q, dy_q;

  logic [DIM_W-1:0]          px, py;
  logic signed [DATA_W-1:0]  re, im;
  logic signed [DATA_W-1:0]  zr, zi, c_r, c_i;
  logic signed [DATA_W-1:0]  zr_next, zi_next;
  logic [ITER_W-1:0]         count;
  logic                      escape;

  logic start, done, handshake, line_end, frame_end;

  fractal_iter_step #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_step (
    .zr     (zr),
    .zi     (zi),
    .cr     (c_r),
    .ci     (c_i),
    .zr_next(zr_next),
    .zi_next(zi_next),
    .escape (escape)
  );

  assign start     = enable && (width != '0) && (height != '0);
  assign done      = escape || (count == max_iter_q);
  assign handshake = m_valid && m_ready;
  assign line_end  = (px == width_q - 1'b1);
  assign frame_end = line_end && (py == height_q - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_INIT;
      ST_INIT: state_next = ST_ITER;
      ST_ITER: if (done) state_next = ST_OUT;
      ST_OUT:  if (handshake) state_next = frame_end ? ST_IDLE : ST_INIT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: frame latch, per-pixel iteration, output register and raster advance
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_JULIA;
      max_iter_q <= '0;
      width_q    <= '0;
      height_q   <= '0;
      cr_q       <= '0;
      ci_q       <= '0;
      x0_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      px         <= '0;
      py         <= '0;
      re         <= '0;
      im         <= '0;
      zr         <= '0;
      zi         <= '0;
      c_r        <= '0;
      c_i        <= '0;
      count      <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_user     <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= fractal_mode_e'(mode);
            max_iter_q <= max_iter;
            width_q    <= width;
            height_q   <= height;
            cr_q       <= cr;
            ci_q       <= ci;
            x0_q       <= x0;
            dx_q       <= dx;
            dy_q       <= dy;
            px         <= '0;
            py         <= '0;
            re         <= x0;
            im         <= y0;
            busy       <= 1'b1;
          end
        end
        ST_INIT: begin
          count <= '0;
          if (mode_q == MODE_MANDELBROT) begin
            zr  <= '0;
            zi  <= '0;
            c_r <= re;
            c_i <= im;
          end else begin
            zr  <= re;
            zi  <= im;
            c_r <= cr_q;
            c_i <= ci_q;
          end
        end
        ST_ITER: begin
          if (done) begin
            m_data  <= count;
            m_valid <= 1'b1;
            m_user  <= (px == '0) && (py == '0);
            m_last  <= line_end;
          end else begin
            zr    <= zr_next;
            zi    <= zi_next;
            count <= count + 1'b1;
          end
        end
        ST_OUT: begin
          // coordinates advance by accumulation so no multiplier is needed per pixel
          if (handshake) begin
            m_valid <= 1'b0;
            if (line_end) begin
              px <= '0;
              py <= py + 1'b1;
              re <= x0_q;
              im <= im + dy_q;
              if (frame_end) busy <= 1'b0;
            end else begin
              px <= px + 1'b1;
              re <= re + dx_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fractal_engine.sv
// Randomised and directed bench for fractal_engine against an arithmetic escape-time model.
module tb_fractal_engine;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 28;
  localparam int ITER_W    = 8;
  localparam int DIM_W     = 16;
  localparam int TIMEOUT   = 20000;

  typedef struct {
    int data;
    int user;
    int last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b0;
  logic                     mode = 1'b0;
  logic [ITER_W-1:0]        max_iter = '0;
  logic [DIM_W-1:0]         width = '0;
  logic [DIM_W-1:0]         height = '0;
  logic signed [DATA_W-1:0] cr = '0, ci = '0, x0 = '0, y0 = '0, dx = '0, dy = '0;
  logic [ITER_W-1:0]        m_data;
  logic                     m_valid;
  logic                     m_ready = 1'b1;
  logic                     m_user, m_last, busy;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beatCount = 0;
  int    frameStart = 0;
  int    latchCyc = 0;
  int    readyPct = 100;
  int    stallBeat = -1;
  int    stallLeft = 0;
  beat_t expQ[$];

  fractal_engine #(
    .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ITER_W(ITER_W), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .max_iter(max_iter),
    .width(width), .height(height), .cr(cr), .ci(ci), .x0(x0), .y0(y0),
    .dx(dx), .dy(dy), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_user(m_user), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Escape-time count of one point, computed with plain 64-bit arithmetic
  function automatic int refIter(input bit mandel, input int maxIter,
                                 input int re, input int im, input int kcr, input int kci);
    longint zr, zi, kr, ki, sr, si, p;
    longint unsigned mag;
    if (mandel) begin
      zr = 0; zi = 0; kr = re; ki = im;
    end else begin
      zr = re; zi = im; kr = kcr; ki = kci;
    end
    for (int n = 0; n <= maxIter; n++) begin
      sr  = zr * zr;
      si  = zi * zi;
      p   = zr * zi;
      mag = $unsigned(sr) + $unsigned(si);
      if (mag > (64'd4 << (2 * FRAC_BITS)) || n == maxIter) return n;
      zr = int'(((sr - si) >>> FRAC_BITS) + kr);
      zi = int'((p >>> (FRAC_BITS - 1)) + ki);
    end
    return maxIter;
  endfunction

  // Sink: chooses m_ready, checks accepted beats and stability while stalled
  always @(negedge clk) begin : sink
    beat_t e;
    bit    r;
    static bit   prevValid = 0, prevReady = 1;
    static int   prevData = 0, prevUser = 0, prevLast = 0;
    if (m_valid === 1'b1 && prevValid && !prevReady) begin
      checkOutput("hold_data", int'(m_data), prevData);
      checkOutput("hold_user", int'(m_user), prevUser);
      checkOutput("hold_last", int'(m_last), prevLast);
    end
    r = ($urandom_range(99) < readyPct);
    if (m_valid === 1'b1 && beatCount == stallBeat && stallLeft > 0) begin
      r = 1'b0;
      stallLeft--;
    end
    m_ready = r;
    if (m_valid === 1'b1 && r) begin
      if (expQ.size() == 0) begin
        checkOutput("extra_beat", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pix_data", int'(m_data), e.data);
        checkOutput("pix_user", int'(m_user), e.user);
        checkOutput("pix_last", int'(m_last), e.last);
      end
      beatCount++;
    end
    prevValid = (m_valid === 1'b1);
    prevReady = r;
    prevData  = int'(m_data);
    prevUser  = int'(m_user);
    prevLast  = int'(m_last);
  end

  // Drive one frame request, queue its expected beats and wait for the latch edge
  task automatic applyStimulus(input bit md, input int mi, input int w, input int h,
                               input int crv, input int civ, input int x0v, input int y0v,
                               input int dxv, input int dyv);
    beat_t e;
    @(negedge clk);
    mode = md; max_iter = ITER_W'(mi); width = DIM_W'(w); height = DIM_W'(h);
    cr = crv; ci = civ; x0 = x0v; y0 = y0v; dx = dxv; dy = dyv;
    for (int py = 0; py < h; py++) begin
      for (int px = 0; px < w; px++) begin
        e.data = refIter(md, mi, x0v + px * dxv, y0v + py * dyv, crv, civ);
        e.user = (px == 0 && py == 0) ? 1 : 0;
        e.last = (px == w - 1) ? 1 : 0;
        expQ.push_back(e);
      end
    end
    frameStart = beatCount;
    latchCyc   = cyc;
    enable     = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy_start", int'(busy), 1);
    enable = 1'b0;
  endtask

  task automatic waitIdle(input int expBeats);
    int t = 0;
    while ((busy !== 1'b0 || expQ.size() != 0) && t < TIMEOUT) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("frame_done", (t < TIMEOUT) ? 1 : 0, 1);
    checkOutput("beat_total", beatCount - frameStart, expBeats);
    expQ.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int t, w, h, mi, sawValid, sawBusy;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", int'(m_valid), 0);
    checkOutput("rst_data",  int'(m_data),  0);
    checkOutput("rst_user",  int'(m_user),  0);
    checkOutput("rst_last",  int'(m_last),  0);
    checkOutput("rst_busy",  int'(busy),    0);
    reset = 1'b0;

    $display("[TB] julia 4x2 at origin");
    applyStimulus(0, 16, 4, 2, 0, 0, 0, 0, 0, 0);
    waitIdle(8);
    repeat (5) @(posedge clk);
    #1 checkOutput("stay_idle", int'(busy), 0);

    $display("[TB] mandelbrot 1x1 latency");
    applyStimulus(1, 255, 1, 1, 0, 0, 32'h2800_0000, 0, 0, 0);
    t = 0;
    while (m_valid !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("latency", cyc - latchCyc, 4);
    waitIdle(1);

    $display("[TB] backpressure on beat 3");
    stallBeat = beatCount + 2;
    stallLeft = 10;
    applyStimulus(0, 16, 4, 2, 0, 0, 0, 0, 0, 0);
    waitIdle(8);
    checkOutput("stall_used", stallLeft, 0);

    $display("[TB] reset with beat 5 pending");
    stallBeat = beatCount + 4;
    stallLeft = 100000;
    applyStimulus(0, 16, 4, 2, 0, 0, 0, 0, 0, 0);
    t = 0;
    while (!(m_valid === 1'b1 && beatCount == stallBeat) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("beat5_pending", (t < 1000) ? 1 : 0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_valid", int'(m_valid), 0);
    checkOutput("midrst_busy",  int'(busy),    0);
    reset = 1'b0;
    expQ.delete();
    stallLeft = 0;
    applyStimulus(0, 3, 2, 2, 0, 0, 0, 0, 0, 0);
    waitIdle(4);

    $display("[TB] width change mid-frame");
    applyStimulus(0, 4, 4, 2, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    width = 16'd8;
    waitIdle(8);
    applyStimulus(0, 4, 8, 1, 0, 0, 0, 0, 0, 0);
    waitIdle(8);

    $display("[TB] max_iter zero and empty frames");
    applyStimulus(1, 0, 3, 2, int'($urandom) >>> 2, 0, int'($urandom) >>> 2,
                  int'($urandom) >>> 2, int'($urandom) >>> 5, int'($urandom) >>> 5);
    waitIdle(6);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      width  = (k == 0) ? 16'd0 : 16'd3;
      height = (k == 0) ? 16'd2 : 16'd0;
      enable = 1'b1;
      sawValid = 0;
      sawBusy  = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (m_valid === 1'b1) sawValid = 1;
        if (busy === 1'b1) sawBusy = 1;
      end
      enable = 1'b0;
      checkOutput("empty_valid", sawValid, 0);
      checkOutput("empty_busy",  sawBusy,  0);
    end

    $display("[TB] randomized frames");
    readyPct = 70;
    for (int f = 0; f < 8; f++) begin
      w  = $urandom_range(5, 1);
      h  = $urandom_range(4, 1);
      mi = $urandom_range(40, 0);
      applyStimulus(1'($urandom_range(1)), mi, w, h,
                    int'($urandom) >>> 2, int'($urandom) >>> 2,
                    int'($urandom) >>> 2, int'($urandom) >>> 2,
                    int'($urandom) >>> 5, int'($urandom) >>> 5);
      waitIdle(w * h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
